// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle sequencer (master) and the datapath/memory (slave).
// No storage here: timing and stall behaviour are owned by the controller.
interface multicycle_controller_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       memread;
   logic       memwrite;
   logic       iord;
   logic       irwrite;
   logic       regwrite;
   logic [1:0] regdst;
   logic [1:0] memtoreg;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [3:0] aluctrl;
   logic [1:0] pcsrc;
   logic       pcen;
   logic       illegal;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output memread, memwrite, iord, irwrite, regwrite, regdst, memtoreg,
             alusrca, alusrcb, aluctrl, pcsrc, pcen, illegal
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  memread, memwrite, iord, irwrite, regwrite, regdst, memtoreg,
             alusrca, alusrcb, aluctrl, pcsrc, pcen, illegal
   );
endinterface

// File: rtl/multicycle_controller.sv
// MIPS-subset multicycle sequencer: 2-5 cycles per instruction with memory ready.
// Backpressure: FETCH/MEMRD/MEMWR hold request and address select while mem_ready is low.
module multicycle_controller (
   input  logic                      clk,
   input  logic                      rst_n,
   multicycle_controller_if.master   bus
);
   localparam logic [3:0] FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
                          MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
                          BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11,
                          JAL    = 4'd12, JR     = 4'd13;

   localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW  = 6'b100011, OP_SW   = 6'b101011,
                          OP_BEQ   = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                          OP_J     = 6'b000010, OP_JAL = 6'b000011;
   localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100,
                          FN_OR  = 6'b100101, FN_SLT = 6'b101010, FN_JR  = 6'b001000;
   localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_AND = 4'b0000,
                          ALU_OR  = 4'b0001, ALU_SLT = 4'b0111;

   logic [3:0] state, state_nxt, decode_nxt;
   logic       is_bne, is_sw;
   logic       funct_ok, decode_illegal;
   logic [3:0] funct_alu;
   logic       memread_s, memwrite_s, irwrite_s, pcen_s, regwrite_s, illegal_s;

   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = ALU_ADD;
      case (bus.funct)
         FN_ADD:  funct_alu = ALU_ADD;
         FN_SUB:  funct_alu = ALU_SUB;
         FN_AND:  funct_alu = ALU_AND;
         FN_OR:   funct_alu = ALU_OR;
         FN_SLT:  funct_alu = ALU_SLT;
         FN_JR:   funct_alu = ALU_ADD;
         default: funct_ok  = 1'b0;
      endcase
   end

   always_comb begin
      decode_nxt     = FETCH;
      decode_illegal = 1'b0;
      case (bus.opcode)
         OP_RTYPE: begin
            if (!funct_ok)               decode_illegal = 1'b1;
            else if (bus.funct == FN_JR) decode_nxt     = JR;
            else                         decode_nxt     = EXEC;
         end
         OP_LW, OP_SW:   decode_nxt = MEMADR;
         OP_BEQ, OP_BNE: decode_nxt = BRANCH;
         OP_ADDI:        decode_nxt = ADDIEX;
         OP_J:           decode_nxt = JUMP;
         OP_JAL:         decode_nxt = JAL;
         default:        decode_illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_nxt = FETCH;
      case (state)
         FETCH:   state_nxt = bus.mem_ready ? DECODE : FETCH;
         DECODE:  state_nxt = decode_nxt;
         MEMADR:  state_nxt = is_sw ? MEMWR : MEMRD;
         MEMRD:   state_nxt = bus.mem_ready ? MEMWB : MEMRD;
         MEMWR:   state_nxt = bus.mem_ready ? FETCH : MEMWR;
         EXEC:    state_nxt = ALUWB;
         ADDIEX:  state_nxt = ADDIWB;
         default: state_nxt = FETCH;
      endcase
   end

   // Opcode flavour is latched in DECODE so later states never depend on the IR port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= FETCH;
         is_bne <= 1'b0;
         is_sw  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == DECODE) begin
            is_bne <= (bus.opcode == OP_BNE);
            is_sw  <= (bus.opcode == OP_SW);
         end
      end
   end

   always_comb begin
      memread_s   = 1'b0;
      memwrite_s  = 1'b0;
      irwrite_s   = 1'b0;
      pcen_s      = 1'b0;
      regwrite_s  = 1'b0;
      illegal_s   = 1'b0;
      bus.iord     = 1'b0;
      bus.regdst   = 2'd0;
      bus.memtoreg = 2'd0;
      bus.alusrca  = 1'b0;
      bus.alusrcb  = 2'd0;
      bus.aluctrl  = ALU_ADD;
      bus.pcsrc    = 2'd0;
      case (state)
         FETCH: begin
            memread_s   = 1'b1;
            bus.alusrcb = 2'd1;
            irwrite_s   = bus.mem_ready;
            pcen_s      = bus.mem_ready;
         end
         DECODE: begin
            bus.alusrcb = 2'd3;
            illegal_s   = decode_illegal;
         end
         MEMADR, ADDIEX: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'd2;
         end
         MEMRD: begin
            memread_s = 1'b1;
            bus.iord  = 1'b1;
         end
         MEMWB: begin
            regwrite_s   = 1'b1;
            bus.memtoreg = 2'd1;
         end
         MEMWR: begin
            memwrite_s = 1'b1;
            bus.iord   = 1'b1;
         end
         EXEC: begin
            bus.alusrca = 1'b1;
            bus.aluctrl = funct_alu;
         end
         ALUWB: begin
            regwrite_s = 1'b1;
            bus.regdst = 2'd1;
         end
         BRANCH: begin
            bus.alusrca = 1'b1;
            bus.aluctrl = ALU_SUB;
            bus.pcsrc   = 2'd1;
            pcen_s      = is_bne ? ~bus.zero : bus.zero;
         end
         ADDIWB: regwrite_s = 1'b1;
         JUMP: begin
            bus.pcsrc = 2'd2;
            pcen_s    = 1'b1;
         end
         JAL: begin
            bus.pcsrc    = 2'd2;
            pcen_s       = 1'b1;
            regwrite_s   = 1'b1;
            bus.regdst   = 2'd2;
            bus.memtoreg = 2'd2;
         end
         JR: begin
            bus.alusrca = 1'b1;
            bus.pcsrc   = 2'd3;
            pcen_s      = 1'b1;
         end
         default: ;
      endcase
   end

   // Strobes are gated by reset directly so an abort never leaks a write.
   assign bus.memread  = memread_s  & rst_n;
   assign bus.memwrite = memwrite_s & rst_n;
   assign bus.irwrite  = irwrite_s  & rst_n;
   assign bus.pcen     = pcen_s     & rst_n;
   assign bus.regwrite = regwrite_s & rst_n;
   assign bus.illegal  = illegal_s  & rst_n;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per-instruction cycle plans from an instruction-level model, checked each cycle.
module tb_multicycle_controller;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   multicycle_controller_if bus();
   multicycle_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   typedef struct packed {
      logic       memread, memwrite, iord, irwrite, regwrite;
      logic [1:0] regdst, memtoreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [3:0] aluctrl;
      logic [1:0] pcsrc;
      logic       pcen, illegal;
   } ctl_t;

   typedef struct { ctl_t exp; string tag; } sb_t;
   typedef struct { ctl_t exp; logic mr; logic z; } cyc_t;

   typedef enum int { K_ILL, K_ALU, K_JR, K_LW, K_SW, K_BEQ, K_BNE, K_ADDI, K_J, K_JAL } kind_t;

   sb_t  sb[$];
   cyc_t plan[$];
   int   errors = 0;
   int   checks = 0;
   sb_t  mon_e;
   ctl_t mon_a;

   function automatic ctl_t observed();
      ctl_t c;
      c.memread  = bus.memread;  c.memwrite = bus.memwrite; c.iord    = bus.iord;
      c.irwrite  = bus.irwrite;  c.regwrite = bus.regwrite; c.regdst  = bus.regdst;
      c.memtoreg = bus.memtoreg; c.alusrca  = bus.alusrca;  c.alusrcb = bus.alusrcb;
      c.aluctrl  = bus.aluctrl;  c.pcsrc    = bus.pcsrc;    c.pcen    = bus.pcen;
      c.illegal  = bus.illegal;
      return c;
   endfunction

   function automatic ctl_t idle();
      ctl_t c = '0;
      c.aluctrl = 4'b0010;
      return c;
   endfunction

   function automatic kind_t classify(logic [5:0] op, logic [5:0] fn);
      case (op)
         6'b000000: case (fn)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: return K_ALU;
            6'b001000: return K_JR;
            default:   return K_ILL;
         endcase
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b000100: return K_BEQ;
         6'b000101: return K_BNE;
         6'b001000: return K_ADDI;
         6'b000010: return K_J;
         6'b000011: return K_JAL;
         default:   return K_ILL;
      endcase
   endfunction

   function automatic logic [3:0] alu_code(logic [5:0] fn);
      case (fn)
         6'b100010: return 4'b0110;
         6'b100100: return 4'b0000;
         6'b100101: return 4'b0001;
         6'b101010: return 4'b0111;
         default:   return 4'b0010;
      endcase
   endfunction

   // mr/z below zero mean "don't care": driven randomly to show they are ignored.
   task automatic add_cyc(ctl_t c, int mr, int z);
      cyc_t r;
      r.exp = c;
      r.mr  = (mr < 0) ? 1'($urandom_range(0, 1)) : 1'(mr);
      r.z   = (z  < 0) ? 1'($urandom_range(0, 1)) : 1'(z);
      plan.push_back(r);
   endtask

   task automatic plan_instr(logic [5:0] op, logic [5:0] fn, logic zv, int fst, int mst);
      ctl_t  c;
      kind_t k = classify(op, fn);
      plan.delete();
      for (int i = 0; i < fst; i++) begin
         c = idle(); c.memread = 1'b1; c.alusrcb = 2'd1;
         add_cyc(c, 0, -1);
      end
      c = idle(); c.memread = 1'b1; c.alusrcb = 2'd1; c.irwrite = 1'b1; c.pcen = 1'b1;
      add_cyc(c, 1, -1);
      c = idle(); c.alusrcb = 2'd3; c.illegal = (k == K_ILL);
      add_cyc(c, -1, -1);
      case (k)
         K_LW, K_SW: begin
            c = idle(); c.alusrca = 1'b1; c.alusrcb = 2'd2;
            add_cyc(c, -1, -1);
            c = idle(); c.iord = 1'b1;
            if (k == K_LW) c.memread = 1'b1; else c.memwrite = 1'b1;
            for (int i = 0; i < mst; i++) add_cyc(c, 0, -1);
            add_cyc(c, 1, -1);
            if (k == K_LW) begin
               c = idle(); c.regwrite = 1'b1; c.memtoreg = 2'd1;
               add_cyc(c, -1, -1);
            end
         end
         K_ALU: begin
            c = idle(); c.alusrca = 1'b1; c.aluctrl = alu_code(fn);
            add_cyc(c, -1, -1);
            c = idle(); c.regwrite = 1'b1; c.regdst = 2'd1;
            add_cyc(c, -1, -1);
         end
         K_BEQ, K_BNE: begin
            c = idle(); c.alusrca = 1'b1; c.aluctrl = 4'b0110; c.pcsrc = 2'd1;
            c.pcen = (k == K_BEQ) ? zv : ~zv;
            add_cyc(c, -1, int'(zv));
         end
         K_ADDI: begin
            c = idle(); c.alusrca = 1'b1; c.alusrcb = 2'd2;
            add_cyc(c, -1, -1);
            c = idle(); c.regwrite = 1'b1;
            add_cyc(c, -1, -1);
         end
         K_J, K_JAL: begin
            c = idle(); c.pcsrc = 2'd2; c.pcen = 1'b1;
            if (k == K_JAL) begin c.regwrite = 1'b1; c.regdst = 2'd2; c.memtoreg = 2'd2; end
            add_cyc(c, -1, -1);
         end
         K_JR: begin
            c = idle(); c.alusrca = 1'b1; c.pcsrc = 2'd3; c.pcen = 1'b1;
            add_cyc(c, -1, -1);
         end
         default: ;
      endcase
   endtask

   task automatic run_plan(string tag, logic [5:0] op, logic [5:0] fn);
      foreach (plan[i]) begin
         @(posedge clk);
         #1;
         if (i == 0) begin bus.opcode = op; bus.funct = fn; end
         bus.mem_ready = plan[i].mr;
         bus.zero      = plan[i].z;
         sb.push_back('{plan[i].exp, $sformatf("%s[%0d]", tag, i)});
      end
   endtask

   task automatic directed(string tag, logic [5:0] op, logic [5:0] fn, logic zv, int fst, int mst);
      plan_instr(op, fn, zv, fst, mst);
      run_plan(tag, op, fn);
   endtask

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && sb.size() > 0) begin
         mon_e = sb.pop_front();
         mon_a = observed();
         checks++;
         if (mon_a !== mon_e.exp) begin
            errors++;
            $display("FAIL %s: got ctl=%05h expected ctl=%05h", mon_e.tag, mon_a, mon_e.exp);
         end
      end
   end

   initial begin
      logic [5:0] op, fn;
      bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
      #3;
      check("reset_strobes",
            {26'd0, bus.irwrite, bus.pcen, bus.regwrite, bus.memwrite, bus.illegal, bus.memread}, 32'd0);
      bus.mem_ready = 1'b0;
      #9 rst_n = 1'b1;

      directed("add",      6'b000000, 6'b100000, 1'b0, 0, 0);
      directed("lw_stall", 6'b100011, 6'b000000, 1'b0, 0, 3);
      directed("beq_z1",   6'b000100, 6'b000000, 1'b1, 0, 0);
      directed("beq_z0",   6'b000100, 6'b000000, 1'b0, 0, 0);
      directed("bne_z1",   6'b000101, 6'b000000, 1'b1, 0, 0);
      directed("bne_z0",   6'b000101, 6'b000000, 1'b0, 0, 0);
      directed("jal",      6'b000011, 6'b000000, 1'b0, 0, 0);
      directed("jr",       6'b000000, 6'b001000, 1'b0, 0, 0);
      directed("ill_op",   6'b111111, 6'b100000, 1'b0, 0, 0);
      directed("ill_fn",   6'b000000, 6'b000111, 1'b0, 0, 0);
      directed("sw_fstall",6'b101011, 6'b000000, 1'b0, 2, 1);
      directed("addi",     6'b001000, 6'b000000, 1'b0, 0, 0);
      directed("j",        6'b000010, 6'b000000, 1'b0, 1, 0);
      directed("slt",      6'b000000, 6'b101010, 1'b0, 0, 0);

      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 9))
            0, 1:    op = 6'b000000;
            2:       op = 6'b100011;
            3:       op = 6'b101011;
            4:       op = 6'b000100;
            5:       op = 6'b000101;
            6:       op = 6'b001000;
            7:       op = 6'b000010;
            8:       op = 6'b000011;
            default: op = 6'($urandom);
         endcase
         case ($urandom_range(0, 6))
            0:       fn = 6'b100000;
            1:       fn = 6'b100010;
            2:       fn = 6'b100100;
            3:       fn = 6'b100101;
            4:       fn = 6'b101010;
            5:       fn = 6'b001000;
            default: fn = 6'($urandom);
         endcase
         plan_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
         run_plan($sformatf("rnd%0d", n), op, fn);
      end

      // Abort an sw while it is stalled in the memory write.
      plan_instr(6'b101011, 6'b000000, 1'b0, 0, 5);
      while (plan.size() > 4) void'(plan.pop_back());
      run_plan("sw_abort", 6'b101011, 6'b000000);
      @(negedge clk);
      #2;
      check("memwrite_before_abort", {31'd0, bus.memwrite}, 32'd1);
      rst_n = 1'b0;
      bus.mem_ready = 1'b0;
      #1;
      check("abort_strobes",
            {26'd0, bus.irwrite, bus.pcen, bus.regwrite, bus.memwrite, bus.illegal, bus.memread}, 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      directed("post_reset_addi", 6'b001000, 6'b000000, 1'b0, 0, 0);

      for (int w = 0; w < 20 && sb.size() > 0; w++) @(negedge clk);
      #1;
      check("scoreboard_drained", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multicycle MIPS-subset core. It steps each instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath mux selects, write strobes and the 4-bit ALU control, and it stalls on a memory ready handshake. It replaces the combinational main/ALU decode pair when the shared single-port memory and single ALU are used.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  instr[31:26], valid from the instruction register
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the current read/write this cycle
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- iord  out  1  memory address: 0 PC, 1 ALUOut
- irwrite  out  1  load instruction register
- regwrite  out  1  register file write
- regdst  out  2  write register: 0 rt, 1 rd, 2 r31
- memtoreg  out  2  write data: 0 ALUOut, 1 MDR, 2 PC
- alusrca  out  1  ALU A: 0 PC, 1 reg A
- alusrcb  out  2  ALU B: 0 reg B, 1 constant 4, 2 signimm, 3 signimm<<2
- aluctrl  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
- pcsrc  out  2  next PC: 0 ALU result, 1 ALUOut, 2 jump target, 3 reg A
- pcen  out  1  PC write enable
- illegal  out  1  one-cycle pulse for an unsupported opcode or funct

## Operation
- Supported instructions:
  - R-type 000000: funct add 100000, sub 100010, and 100100, or 100101, slt 101010, jr 001000.
  - lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010, jal 000011.
- Outputs are Moore (from state), except for three terms:
  - pcen in BRANCH depends on zero.
  - irwrite and pcen in FETCH are gated by mem_ready.
  - aluctrl in EXEC is taken from funct.
- Unlisted outputs are 0 in every state. Default aluctrl is add.
- State actions and transitions:
  - FETCH: memread=1, iord=0, alusrca=0, alusrcb=1, pcsrc=0. When mem_ready=1: irwrite=1, pcen=1, go to DECODE. Otherwise hold with irwrite=0, pcen=0.
  - DECODE: alusrca=0, alusrcb=3, add (branch target to ALUOut). Next state by opcode:
    - lw/sw → MEMADR; R-type with legal funct ≠ jr → EXEC; jr → JR.
    - beq/bne → BRANCH; addi → ADDIEX; j → JUMP; jal → JAL.
    - Anything else: illegal=1, go to FETCH.
  - MEMADR: alusrca=1, alusrcb=2, add. lw → MEMRD, sw → MEMWR.
  - MEMRD: memread=1, iord=1. Hold until mem_ready, then MEMWB.
  - MEMWB: regwrite=1, regdst=0, memtoreg=1, then FETCH.
  - MEMWR: memwrite=1, iord=1. Hold until mem_ready, then FETCH.
  - EXEC: alusrca=1, alusrcb=0, aluctrl from funct, then ALUWB.
  - ALUWB: regwrite=1, regdst=1, memtoreg=0, then FETCH.
  - BRANCH: alusrca=1, alusrcb=0, sub, pcsrc=1. pcen=zero for beq, ~zero for bne. Then FETCH.
  - ADDIEX: alusrca=1, alusrcb=2, add, then ADDIWB.
  - ADDIWB: regwrite=1, regdst=0, memtoreg=0, then FETCH.
  - JUMP: pcsrc=2, pcen=1, then FETCH.
  - JAL: pcsrc=2, pcen=1, regwrite=1, regdst=2, memtoreg=2 (PC is already PC+4), then FETCH.
  - JR: alusrca=1, pcsrc=3, pcen=1, then FETCH.
- The opcode decode registered for branch polarity (beq vs bne) is captured in DECODE. The IR is stable after FETCH, so reading opcode directly is also legal.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

## Timing
- Reset (rst_n low, asynchronous): state = FETCH.
  - Strobes irwrite, pcen, regwrite, memwrite, illegal and memread are forced 0 while rst_n=0.
  - The first fetch request is issued in the first cycle after rst_n rises.
- Latency with mem_ready tied high, in cycles from FETCH entry to the next FETCH entry:
  - R-type 4, addi 4, lw 5, sw 4.
  - beq/bne 3, j 3, jal 3, jr 3, illegal 2.
- Each cycle with mem_ready low in FETCH, MEMRD or MEMWR adds exactly one cycle. memread/memwrite stay asserted and the address select stays unchanged.
- Strobe pulse widths:
  - irwrite and pcen pulse for exactly one cycle per fetch.
  - regwrite is one cycle per writeback state.
- Reset asserted mid-instruction aborts immediately. No pending write strobe may be seen after rst_n falls.

## Test plan
- add (opcode 0, funct 100000), mem_ready=1: sequence FETCH, DECODE, EXEC, ALUWB.
  - EXEC has aluctrl=0010, alusrcb=0.
  - ALUWB has regwrite=1, regdst=1, memtoreg=0. Back to FETCH on cycle 5.
- lw with mem_ready held low for 3 cycles in MEMRD: memread=1, iord=1 held for 4 cycles. Then MEMWB with regwrite=1, memtoreg=1. Total 8 cycles.
- beq with zero=1: pcen=1, pcsrc=1 in BRANCH. Repeat with zero=0: pcen=0. bne inverts both cases.
- jal: a single cycle with pcen=1, pcsrc=2, regwrite=1, regdst=2, memtoreg=2. jr: pcsrc=3, pcen=1, regwrite=0.
- Opcode 111111, then R-type funct 000111: each gives illegal=1 for one DECODE cycle, no regwrite/memwrite, FETCH next.
- Reset pulse during MEMWR with mem_ready low: memwrite drops asynchronously. After release the state is FETCH with memread=1, iord=0.
